// File: rtl/rr_arbiter_8to1.sv
// rr_arbiter_8to1: round-robin arbiter for eight requesters that share one
// N-bit datapath lane. The winner's word is captured into a registered
// valid/ready output stage, and the winner's index is exported as out_sel.
// Optional feature macro: ARB_LOCK_EN. When it is defined, a requester that
// holds lock can keep the lane for up to MAX_BURST consecutive beats.
module rr_arbiter_8to1 #(
   parameter int N         = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req,
   input  logic [8*N-1:0]   data_in,
   input  logic [7:0]       lock,
   output logic [7:0]       ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [2:0]       out_sel
);

   typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

   state_t     state;
   state_t     stateNext;
   logic [2:0] ptr;
   logic [2:0] rrWinner;
   logic [2:0] winner;
   logic [2:0] scanIdx;
   logic       scanFound;
   logic       anyReq;
   logic       load;
   logic       advancePtr;

   assign anyReq = |req;
   assign load   = anyReq & (~out_valid | out_ready) & ~rst;

   // Round-robin scan: the first requester at or after ptr, wrapping 7 -> 0
   always_comb begin
      rrWinner  = ptr;
      scanIdx   = ptr;
      scanFound = 1'b0;
      for (int i = 0; i < 8; i++) begin
         scanIdx = ptr + 3'(i);
         if (!scanFound && req[scanIdx]) begin
            rrWinner  = scanIdx;
            scanFound = 1'b1;
         end
      end
   end

`ifdef ARB_LOCK_EN
   localparam int BW = $clog2(MAX_BURST + 1);

   logic [BW-1:0] burst;
   logic          lockHold;

   assign lockHold = lock[out_sel] & req[out_sel] & out_valid &
                     (burst < BW'(MAX_BURST - 1));

   // A locked burst keeps the current owner and freezes the pointer
   always_comb begin
      winner     = lockHold ? out_sel : rrWinner;
      advancePtr = ~lockHold;
   end

   // Count consecutive locked beats; any round-robin load restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         burst <= '0;
      end else if (load) begin
         burst <= lockHold ? burst + 1'b1 : '0;
      end
   end
`else
   logic unusedLock;
   assign unusedLock = ^lock;

   // Without burst locking every load is pure round-robin
   always_comb begin
      winner     = rrWinner;
      advancePtr = 1'b1;
   end
`endif

   // State register: IDLE means the output stage is empty, FULL means it holds a word
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state: a load always fills the stage, and a retire with no new load empties it
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (load) stateNext = FULL;
         FULL:    if (out_ready && !load) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Outputs: valid follows the state, and ack marks the winner only in a capture cycle
   always_comb begin
      out_valid = (state == FULL);
      ack       = 8'd0;
      if (load) begin
         ack = 8'd1 << winner;
      end
   end

   // Capture the winner's word and move priority to the requester just after it
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_sel  <= 3'd0;
         ptr      <= 3'd0;
      end else if (load) begin
         out_data <= data_in[int'(winner) * N +: N];
         out_sel  <= winner;
         if (advancePtr) begin
            ptr <= winner + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8to1.sv
// tb_rr_arbiter_8to1: directed bench for rr_arbiter_8to1, which checks the
// design against a behavioural model of the arbitration rules on every cycle
// and pins that model with hand-computed expectations.
module tb_rr_arbiter_8to1;

   localparam int N         = 32;
   localparam int MAX_BURST = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     req = 8'd0;
   logic [8*N-1:0] dataIn;
   logic [7:0]     lock = 8'd0;
   logic [7:0]     ack;
   logic           outValid;
   logic           outReady = 1'b0;
   logic [N-1:0]   outData;
   logic [2:0]     outSel;

   int testsRun = 0;
   int testsFailed = 0;

   // Behavioural model state: the priority pointer, the output stage, and the burst length
   int       mPtr = 0;
   int       mValid = 0;
   int       mSel = 0;
   int       mBurst = 0;
   logic [N-1:0] mData = '0;

   rr_arbiter_8to1 #(.N(N), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (dataIn),
      .lock      (lock),
      .ack       (ack),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .out_sel   (outSel)
   );

   // Free-running clock with a 10-unit period
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive a new input vector just after the next rising edge
   task automatic applyStimulus(input logic [7:0] reqV, input logic [7:0] lockV,
                                input logic readyV, input logic rstV);
      @(posedge clk);
      #1;
      req      = reqV;
      lock     = lockV;
      outReady = readyV;
      rst      = rstV;
   endtask

   // Model the winner selection from the arbitration rules
   function automatic int modelWinner(output int locked);
      locked = 0;
`ifdef ARB_LOCK_EN
      if (mValid != 0 && lock[mSel] && req[mSel] && mBurst < MAX_BURST - 1) begin
         locked = 1;
         return mSel;
      end
`endif
      for (int i = 0; i < 8; i++) begin
         if (req[(mPtr + i) % 8]) return (mPtr + i) % 8;
      end
      return -1;
   endfunction

   // Advance the model once per rising edge, using the inputs that were stable at that edge
   always @(posedge clk) begin
      int w;
      int locked;
      if (rst) begin
         mValid <= 0;
         mData  <= '0;
         mSel   <= 0;
         mPtr   <= 0;
         mBurst <= 0;
      end else if (req != 8'd0 && (mValid == 0 || outReady)) begin
         w = modelWinner(locked);
         mValid <= 1;
         mData  <= dataIn[w*N +: N];
         mSel   <= w;
         if (locked != 0) begin
            mBurst <= mBurst + 1;
         end else begin
            mBurst <= 0;
            mPtr   <= (w + 1) % 8;
         end
      end else if (mValid != 0 && outReady) begin
         mValid <= 0;
      end
   end

   // Compare the design against the model on every falling edge outside reset
   always @(negedge clk) begin
      int w;
      int locked;
      logic [7:0] expAck;
      if (!rst) begin
         expAck = 8'd0;
         if (req != 8'd0 && (mValid == 0 || outReady)) begin
            w = modelWinner(locked);
            expAck = 8'd1 << w;
         end
         checkOutput("model_ack", {24'd0, ack}, {24'd0, expAck});
         checkOutput("model_valid", {31'd0, outValid}, mValid[31:0]);
         if (mValid != 0) begin
            checkOutput("model_data", outData, mData);
            checkOutput("model_sel", {29'd0, outSel}, mSel[31:0]);
         end
      end
   end

   initial begin
      int ack3Pulses;
      logic [2:0] lockSeq [10];

      for (int k = 0; k < 8; k++) begin
         dataIn[k*N +: N] = 32'hA5A5_0000 + 32'(k) * 32'h111;
      end

      // Reset: the output stage must come up empty and zeroed
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("reset_valid", {31'd0, outValid}, 32'd0);
      checkOutput("reset_data", outData, 32'd0);
      checkOutput("reset_sel", {29'd0, outSel}, 32'd0);
      checkOutput("reset_ack", {24'd0, ack}, 32'd0);

      // All eight requesting with a ready sink: grants rotate 0..7,0 with no bubbles
      applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         else @(negedge clk);
         checkOutput("rr_ack", {24'd0, ack}, 32'd1 << (c % 8));
         checkOutput("rr_valid", {31'd0, outValid}, (c == 0) ? 32'd0 : 32'd1);
         if (c > 0) checkOutput("rr_sel", {29'd0, outSel}, 32'((c - 1) % 8));
      end

      // Requests vanish while full and ready: the stage drains and no ack appears
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("drain_ack", {24'd0, ack}, 32'd0);
      checkOutput("drain_sel", {29'd0, outSel}, 32'd0);
      @(negedge clk);
      checkOutput("drain_valid", {31'd0, outValid}, 32'd0);
      checkOutput("drain_ack2", {24'd0, ack}, 32'd0);

      // The pointer stayed at 1, so of requesters 0 and 1 the winner is 1
      applyStimulus(8'h03, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("ptr_kept_ack", {24'd0, ack}, 32'h02);
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);

      // Backpressure: word 3 is held for three cycles and acknowledged exactly once
      dataIn[3*N +: N] = 32'hDEAD_BEEF;
      applyStimulus(8'h08, 8'h00, 1'b0, 1'b0);
      ack3Pulses = 0;
      @(negedge clk);
      if (ack[3]) ack3Pulses++;
      checkOutput("hold_first_ack", {24'd0, ack}, 32'h08);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (ack[3]) ack3Pulses++;
         checkOutput("hold_data", outData, 32'hDEAD_BEEF);
         checkOutput("hold_sel", {29'd0, outSel}, 32'd3);
         checkOutput("hold_valid", {31'd0, outValid}, 32'd1);
      end
      checkOutput("hold_ack_pulses", 32'(ack3Pulses), 32'd1);
      applyStimulus(8'h08, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("retire_ack", {24'd0, ack}, 32'h08);

      // Wrap: grant 6, then requesters 7 and 0 win in order, and ptr returns to 1
      applyStimulus(8'h40, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("wrap_ack6", {24'd0, ack}, 32'h40);
      applyStimulus(8'h81, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("wrap_ack7", {24'd0, ack}, 32'h80);
      @(negedge clk);
      checkOutput("wrap_ack0", {24'd0, ack}, 32'h01);
      checkOutput("wrap_sel7", {29'd0, outSel}, 32'd7);
      applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("wrap_sel0", {29'd0, outSel}, 32'd0);
      checkOutput("wrap_ptr1", {24'd0, ack}, 32'h02);

      // Reset mid-transfer with a stalled sink: the stage empties, then a fresh request works
      applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("midrst_valid", {31'd0, outValid}, 32'd0);
      checkOutput("midrst_ack", {24'd0, ack}, 32'd0);
      applyStimulus(8'h40, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("midrst_ack6", {24'd0, ack}, 32'h40);
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("midrst_sel6", {29'd0, outSel}, 32'd6);
      checkOutput("midrst_valid6", {31'd0, outValid}, 32'd1);
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);

`ifdef ARB_LOCK_EN
      // Locked burst: requester 0 keeps the lane for four beats, then yields one beat to 1
      lockSeq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      applyStimulus(8'h03, 8'h01, 1'b1, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("lock_sel", {29'd0, outSel}, {29'd0, lockSeq[i]});
      end
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
`else
      lockSeq = '{default: 3'd0};
      // Without the lock feature, lock must not hold the lane: 0 and 1 simply alternate
      applyStimulus(8'h03, 8'h01, 1'b1, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("nolock_sel", {29'd0, outSel}, 32'(i % 2));
      end
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
`endif

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
